operand_entry_ctrl: RTL and testbench
=====================================

Name: operand_entry_ctrl

Overview:
Parametrised keypad front end for the RISC-V calculator demo. It collects NUM_OPERANDS BCD operands of DIGITS digits each plus one operator from strobed key codes. It writes them as binary words to memory-mapped CPU locations over a req/ack bus, enables the CPU, waits for completion with a timeout, then reads back and holds the result for display. Sits between keysync/edge detection and the data memory bus.

Parameters:
DIGITS, 2, BCD digits per operand (1..8)
NUM_OPERANDS, 2, operands per calculation (2..4)
ADDR_BASE, 220, address of operand 0; operand k at ADDR_BASE+4k
OP_ADDR, 260, address of operator word
RESULT_ADDR, 280, address of result word
IDLE_ADDR, 320, bus_addr value when bus idle
TIMEOUT, 1000000, max CPU cycles before error

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_valid  in  1  one-cycle key strobe (already synchronised/edge-detected)
key_code  in  5  0-9 digit, 10 enter, 11 clear, 12 backspace, 16-19 operator; all others ignored
bus_req  out  1  bus transaction request
bus_we  out  1  1 = write, 0 = read
bus_addr  out  32  transaction address
bus_wdata  out  32  write data
bus_rdata  in  32  read data, valid with bus_ack
bus_ack  in  1  one-cycle completion of current transaction
cpu_en  out  1  CPU run enable
cpu_done  in  1  CPU completion pulse
disp_bcd  out  4*DIGITS  nibbles shown on seven-segment displays
disp_sel  out  3  index of field being shown (operand k = k, operator = 7 during OPSEL)
state_o  out  3  FSM state for LEDs
err  out  1  timeout/overflow indicator

Behaviour:
- Reset: state ENTRY, operand index 0, all digit buffers 0, operator 0, result 0. Outputs: bus_req=0, bus_we=0, bus_addr=IDLE_ADDR, bus_wdata=0, cpu_en=0, disp_bcd=0, disp_sel=0, err=0. rst mid-transaction drops bus_req/cpu_en on the next edge; a pending ack is ignored.
- States, encoded in state_o: ENTRY=0, OPSEL=1, WRITE=2, RUN=3, READ=4, SHOW=5, ERROR=6.
- Keys are sampled only when key_valid=1 and only in ENTRY, OPSEL, SHOW and ERROR. Elsewhere they are dropped. Effects are registered at the edge where key_valid is high.
- ENTRY, operand k:
  - Digit: buffer <= {buffer[4*DIGITS-5:0], digit} when fewer than DIGITS digits are entered. Otherwise the digit is ignored.
  - Backspace: buffer >>= 4 and count-1, with a floor at 0.
  - Enter: if k==0 go to OPSEL; if k<NUM_OPERANDS-1 go to k+1; if k==NUM_OPERANDS-1 go to WRITE.
  - Zero digits entered plus enter gives operand value 0.
- OPSEL:
  - Operator key latches op=key_code-16.
  - Enter advances to ENTRY k=1 only if an operator has been latched since the last clear. Otherwise enter is ignored.
  - Digits and backspace are ignored.
- Clear, in ENTRY or OPSEL: return to ENTRY k=0 and zero all buffers and the operator.
- WRITE:
  - Issues NUM_OPERANDS+1 writes in order: operand 0..N-1, then the operator at OP_ADDR.
  - Each write holds bus_req=1, bus_we=1, with addr and wdata stable until bus_ack.
  - On ack, the next write is presented on the following cycle. bus_req stays high between writes.
  - The ack of the last write goes to RUN.
  - wdata is the operand BCD converted to binary (sum of digit_i*10^i, zero-extended to 32 bits). The operator word is zero-extended op.
- RUN:
  - cpu_en=1. A cycle counter starts at 0.
  - On cpu_done, go to READ with cpu_en=0 the next cycle.
  - If the counter reaches TIMEOUT-1 without done, go to ERROR.
  - cpu_done coincident with the final count goes to READ; done takes priority.
- READ:
  - bus_req=1, bus_we=0, bus_addr=RESULT_ADDR.
  - On ack, capture bus_rdata into result and go to SHOW.
- SHOW:
  - disp_bcd = binary-to-BCD of result, for 0 to 10^DIGITS-1.
  - If result >= 10^DIGITS, err=1 and disp_bcd is all nibbles 9 (saturated).
  - Enter or clear goes to ENTRY k=0 with buffers cleared and err=0.
- ERROR: err=1, disp_bcd=all 0xF (blank). Enter or clear goes to ENTRY k=0 and clears err.
- Display source:
  - ENTRY: current operand buffer, disp_sel=k.
  - OPSEL: {zeros, op}, disp_sel=7.
  - WRITE/RUN/READ: last operand buffer.
- bus_addr is IDLE_ADDR whenever bus_req=0.
- Latency: the final enter to the first bus_req is 1 cycle. The last ack to cpu_en is 1 cycle.

Test Plan:
- Keys 4,2,enter,op17,enter,1,7,enter (DIGITS=2, N=2) -> writes (220,42),(224,17),(260,1) in order with ack after 3 wait cycles each, then cpu_en=1.
- From RUN, cpu_done pulse, then READ ack with rdata=59 -> state SHOW, disp_bcd=0x59, err=0; enter -> ENTRY k=0, disp_bcd=0.
- Digits 1,2,3 with DIGITS=2 -> buffer 0x12; backspace -> 0x01; backspace x3 -> 0x00, no underflow.
- Enter in OPSEL with no operator latched -> stays OPSEL. Clear in OPSEL -> ENTRY k=0, op=0.
- TIMEOUT=16, no cpu_done -> ERROR exactly 16 cycles after RUN entry, err=1, cpu_en=0. Separately, done on cycle 15 -> READ, no error.
- READ returns rdata=150 with DIGITS=2 -> disp_bcd=0x99, err=1. Separately, rst asserted mid-WRITE -> bus_req=0 and state_o=0 next cycle.

Source files
------------

// File: rtl/operand_entry_ctrl_if.sv
// Request/acknowledge data-memory bus between the keypad front end and CPU data memory.
// The front end is master; memory (or the bench) is slave.
interface operand_entry_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/operand_entry_ctrl.sv
// Keypad operand/operator collector for the calculator demo: writes BCD operands as binary
// words to CPU memory, runs the CPU with a timeout, then reads back and displays the result.
module operand_entry_ctrl #(
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned NUM_OPERANDS = 2,
  parameter logic [31:0] ADDR_BASE    = 32'd220,
  parameter logic [31:0] OP_ADDR      = 32'd260,
  parameter logic [31:0] RESULT_ADDR  = 32'd280,
  parameter logic [31:0] IDLE_ADDR    = 32'd320,
  parameter int unsigned TIMEOUT      = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [4:0]            key_code,
  operand_entry_ctrl_if.master  bus,
  output logic                  cpu_en,
  input  logic                  cpu_done,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic [2:0]            disp_sel,
  output logic [2:0]            state_o,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned KW = (NUM_OPERANDS > 2) ? 2 : 1;
  localparam int unsigned IW = $clog2(NUM_OPERANDS + 1);

  typedef enum logic [2:0] {
    S_ENTRY = 3'd0,
    S_OPSEL = 3'd1,
    S_WRITE = 3'd2,
    S_RUN   = 3'd3,
    S_READ  = 3'd4,
    S_SHOW  = 3'd5,
    S_ERROR = 3'd6
  } state_e;

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < int'(n); i++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0] MAX_VAL      = pow10(DIGITS) - 32'd1;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  function automatic logic [31:0] bcd2bin(input logic [W-1:0] bcd);
    logic [31:0] acc;
    acc = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--)
      acc = (acc << 3) + (acc << 1) + 32'(bcd[4*i +: 4]);
    return acc;
  endfunction

  // Shift-add-3; the caller only uses it once the value is known to fit in DIGITS nibbles.
  function automatic logic [W-1:0] bin2bcd(input logic [31:0] bin);
    logic [W-1:0] bcd;
    bcd = '0;
    for (int i = 31; i >= 0; i--) begin
      for (int d = 0; d < int'(DIGITS); d++)
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      bcd = {bcd[W-2:0], bin[i]};
    end
    return bcd;
  endfunction

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    buf_q [NUM_OPERANDS];
  logic [W-1:0]    buf_d [NUM_OPERANDS];
  logic [3:0]      cnt_q [NUM_OPERANDS];
  logic [3:0]      cnt_d [NUM_OPERANDS];
  logic [1:0]      op_q, op_d;
  logic            op_valid_q, op_valid_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [31:0]     timer_q, timer_d;
  logic [31:0]     result_q, result_d;

  logic            is_digit, is_enter, is_clear, is_bksp, is_op;
  logic            clear_all;
  logic [W-1:0]    cur_buf;
  logic            bus_req, bus_we;
  logic [31:0]     bus_addr, bus_wdata;

  assign is_digit = (key_code < 5'd10);
  assign is_enter = (key_code == 5'd10);
  assign is_clear = (key_code == 5'd11);
  assign is_bksp  = (key_code == 5'd12);
  assign is_op    = (key_code[4:2] == 3'b100);

  assign cur_buf  = buf_q[k_q];

  // NOTE: every variable gets its default before the case so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    op_valid_d = op_valid_q;
    wr_idx_d   = wr_idx_q;
    timer_d    = timer_q;
    result_d   = result_q;
    clear_all  = 1'b0;

    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = IDLE_ADDR;
    bus_wdata  = '0;
    cpu_en     = 1'b0;
    disp_bcd   = cur_buf;
    disp_sel   = 3'(k_q);
    err        = 1'b0;

    unique case (state_q)
      S_ENTRY: begin
        if (key_valid) begin
          if (is_clear) begin
            clear_all = 1'b1;
          end else if (is_digit) begin
            if (cnt_q[k_q] < 4'(DIGITS)) begin
              buf_d[k_q] = W'({cur_buf, key_code[3:0]});
              cnt_d[k_q] = cnt_q[k_q] + 4'd1;
            end
          end else if (is_bksp) begin
            if (cnt_q[k_q] != 4'd0) begin
              buf_d[k_q] = cur_buf >> 4;
              cnt_d[k_q] = cnt_q[k_q] - 4'd1;
            end
          end else if (is_enter) begin
            if (k_q == '0) begin
              state_d = S_OPSEL;
            end else if (k_q == KW'(NUM_OPERANDS - 1)) begin
              state_d  = S_WRITE;
              wr_idx_d = '0;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
      end

      S_OPSEL: begin
        disp_bcd = W'(op_q);
        disp_sel = 3'd7;
        if (key_valid) begin
          if (is_clear) begin
            clear_all = 1'b1;
          end else if (is_op) begin
            op_d       = key_code[1:0];
            op_valid_d = 1'b1;
          end else if (is_enter && op_valid_q) begin
            state_d = S_ENTRY;
            k_d     = KW'(1);
          end
        end
      end

      S_WRITE: begin
        bus_req  = 1'b1;
        bus_we   = 1'b1;
        disp_bcd = buf_q[NUM_OPERANDS-1];
        disp_sel = 3'(NUM_OPERANDS - 1);
        if (wr_idx_q < IW'(NUM_OPERANDS)) begin
          bus_addr  = ADDR_BASE + 32'({wr_idx_q, 2'b00});
          bus_wdata = bcd2bin(buf_q[wr_idx_q[KW-1:0]]);
        end else begin
          bus_addr  = OP_ADDR;
          bus_wdata = 32'(op_q);
        end
        if (bus.bus_ack) begin
          if (wr_idx_q == IW'(NUM_OPERANDS)) begin
            state_d = S_RUN;
            timer_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end

      S_RUN: begin
        cpu_en   = 1'b1;
        disp_bcd = buf_q[NUM_OPERANDS-1];
        disp_sel = 3'(NUM_OPERANDS - 1);
        // Done wins over a timeout landing on the same cycle.
        if (cpu_done)                     state_d = S_READ;
        else if (timer_q == TIMEOUT_LAST) state_d = S_ERROR;
        else                              timer_d = timer_q + 32'd1;
      end

      S_READ: begin
        bus_req  = 1'b1;
        bus_addr = RESULT_ADDR;
        disp_bcd = buf_q[NUM_OPERANDS-1];
        disp_sel = 3'(NUM_OPERANDS - 1);
        if (bus.bus_ack) begin
          result_d = bus.bus_rdata;
          state_d  = S_SHOW;
        end
      end

      S_SHOW: begin
        disp_sel = '0;
        if (result_q > MAX_VAL) begin
          err      = 1'b1;
          disp_bcd = {DIGITS{4'h9}};
        end else begin
          disp_bcd = bin2bcd(result_q);
        end
        if (key_valid && (is_enter || is_clear)) clear_all = 1'b1;
      end

      S_ERROR: begin
        err      = 1'b1;
        disp_bcd = '1;
        disp_sel = '0;
        if (key_valid && (is_enter || is_clear)) clear_all = 1'b1;
      end

      default: state_d = S_ENTRY;
    endcase

    if (clear_all) begin
      state_d    = S_ENTRY;
      k_d        = '0;
      op_d       = '0;
      op_valid_d = 1'b0;
      for (int i = 0; i < int'(NUM_OPERANDS); i++) begin
        buf_d[i] = '0;
        cnt_d[i] = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ENTRY;
      k_q        <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      wr_idx_q   <= '0;
      timer_q    <= '0;
      result_q   <= '0;
      // NOTE: the operand buffers are a handful of flops, not a RAM, so they take the reset too.
      for (int i = 0; i < int'(NUM_OPERANDS); i++) begin
        buf_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      wr_idx_q   <= wr_idx_d;
      timer_q    <= timer_d;
      result_q   <= result_d;
    end
  end

  assign bus.bus_req   = bus_req;
  assign bus.bus_we    = bus_we;
  assign bus.bus_addr  = bus_addr;
  assign bus.bus_wdata = bus_wdata;
  assign state_o       = state_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl (DIGITS=2, two operands, TIMEOUT=16) with a scripted
// memory responder driven from the main sequence.
module tb_operand_entry_ctrl;

  localparam logic [4:0] K_ENTER = 5'd10;
  localparam logic [4:0] K_CLEAR = 5'd11;
  localparam logic [4:0] K_BKSP  = 5'd12;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [4:0] key_code;
  logic       cpu_en;
  logic       cpu_done;
  logic [7:0] disp_bcd;
  logic [2:0] disp_sel;
  logic [2:0] state_o;
  logic       err;

  int checks = 0;
  int errors = 0;

  operand_entry_ctrl_if bus ();

  operand_entry_ctrl #(
    .DIGITS       (2),
    .NUM_OPERANDS (2),
    .TIMEOUT      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .bus       (bus),
    .cpu_en    (cpu_en),
    .cpu_done  (cpu_done),
    .disp_bcd  (disp_bcd),
    .disp_sel  (disp_sel),
    .state_o   (state_o),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 5'd0;
  endtask

  // Present-then-hold check over three wait cycles, then a one-cycle ack.
  task automatic slow_write(input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < 4; i++) begin
      check("wr_req",   32'(bus.bus_req), 32'd1);
      check("wr_we",    32'(bus.bus_we),  32'd1);
      check("wr_addr",  bus.bus_addr,     addr);
      check("wr_wdata", bus.bus_wdata,    data);
      if (i < 3) @(negedge clk);
    end
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
  endtask

  task automatic fast_write(input logic [31:0] addr, input logic [31:0] data);
    check("fw_req",   32'(bus.bus_req), 32'd1);
    check("fw_addr",  bus.bus_addr,     addr);
    check("fw_wdata", bus.bus_wdata,    data);
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
  endtask

  // Zero operands with operator 16, acked immediately; returns on the first RUN cycle.
  task automatic reach_run();
    press(K_ENTER);
    press(5'd16);
    press(K_ENTER);
    press(K_ENTER);
    fast_write(32'd220, 32'd0);
    fast_write(32'd224, 32'd0);
    fast_write(32'd260, 32'd0);
    check("run_state", 32'(state_o), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected summary before time limit");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    rst         = 1'b1;
    key_valid   = 1'b0;
    key_code    = 5'd0;
    cpu_done    = 1'b0;
    bus.bus_ack = 1'b0;
    bus.bus_rdata = 32'd0;
    repeat (3) @(negedge clk);

    check("rst_state", 32'(state_o),     32'd0);
    check("rst_req",   32'(bus.bus_req), 32'd0);
    check("rst_we",    32'(bus.bus_we),  32'd0);
    check("rst_addr",  bus.bus_addr,     32'd320);
    check("rst_wdata", bus.bus_wdata,    32'd0);
    check("rst_cpu_en", 32'(cpu_en),     32'd0);
    check("rst_disp",  32'(disp_bcd),    32'd0);
    check("rst_sel",   32'(disp_sel),    32'd0);
    check("rst_err",   32'(err),         32'd0);
    rst = 1'b0;

    // Full calculation: 42 op1 17.
    press(5'd4);
    press(5'd2);
    check("e0_disp", 32'(disp_bcd), 32'h42);
    check("e0_sel",  32'(disp_sel), 32'd0);
    press(K_ENTER);
    check("opsel_state", 32'(state_o),  32'd1);
    check("opsel_sel",   32'(disp_sel), 32'd7);
    press(5'd17);
    check("opsel_disp", 32'(disp_bcd), 32'h01);
    press(K_ENTER);
    check("e1_state", 32'(state_o),  32'd0);
    check("e1_sel",   32'(disp_sel), 32'd1);
    press(5'd1);
    press(5'd7);
    check("e1_disp", 32'(disp_bcd), 32'h17);
    press(K_ENTER);
    check("write_state", 32'(state_o), 32'd2);
    slow_write(32'd220, 32'd42);
    slow_write(32'd224, 32'd17);
    slow_write(32'd260, 32'd1);
    check("run_state0",  32'(state_o),     32'd3);
    check("run_cpu_en",  32'(cpu_en),      32'd1);
    check("run_req",     32'(bus.bus_req), 32'd0);
    check("run_addr",    bus.bus_addr,     32'd320);

    // Completion and readback of 59.
    repeat (2) @(negedge clk);
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    check("read_state",  32'(state_o),     32'd4);
    check("read_cpu_en", 32'(cpu_en),      32'd0);
    check("read_req",    32'(bus.bus_req), 32'd1);
    check("read_we",     32'(bus.bus_we),  32'd0);
    check("read_addr",   bus.bus_addr,     32'd280);
    @(negedge clk);
    bus.bus_rdata = 32'd59;
    bus.bus_ack   = 1'b1;
    @(negedge clk);
    bus.bus_ack   = 1'b0;
    check("show_state", 32'(state_o),     32'd5);
    check("show_disp",  32'(disp_bcd),    32'h59);
    check("show_err",   32'(err),         32'd0);
    check("show_req",   32'(bus.bus_req), 32'd0);
    press(K_ENTER);
    check("back_state", 32'(state_o),  32'd0);
    check("back_disp",  32'(disp_bcd), 32'h00);
    check("back_sel",   32'(disp_sel), 32'd0);

    // Digit limit and backspace floor.
    press(5'd1);
    press(5'd2);
    press(5'd3);
    check("dig_limit", 32'(disp_bcd), 32'h12);
    press(K_BKSP);
    check("bksp1", 32'(disp_bcd), 32'h01);
    repeat (3) press(K_BKSP);
    check("bksp_floor", 32'(disp_bcd), 32'h00);
    press(5'd5);
    press(5'd6);
    press(5'd7);
    check("refill", 32'(disp_bcd), 32'h56);

    // OPSEL: enter needs an operator; digits ignored; clear zeroes everything.
    press(K_ENTER);
    press(K_ENTER);
    check("opsel_noop_enter", 32'(state_o), 32'd1);
    press(5'd19);
    press(5'd5);
    check("opsel_op19", 32'(disp_bcd), 32'h03);
    press(K_CLEAR);
    check("clr_state", 32'(state_o),  32'd0);
    check("clr_disp",  32'(disp_bcd), 32'h00);
    press(K_ENTER);
    check("clr_op",    32'(disp_bcd), 32'h00);
    press(K_ENTER);
    check("clr_opvalid", 32'(state_o), 32'd1);
    press(K_CLEAR);

    // Timeout: ERROR exactly 16 cycles after RUN entry.
    reach_run();
    repeat (15) @(negedge clk);
    check("to_still_run", 32'(state_o), 32'd3);
    check("to_cpu_en",    32'(cpu_en),  32'd1);
    @(negedge clk);
    check("to_state",  32'(state_o),  32'd6);
    check("to_err",    32'(err),      32'd1);
    check("to_cpu_en_off", 32'(cpu_en), 32'd0);
    check("to_disp",   32'(disp_bcd), 32'hFF);
    press(K_ENTER);
    check("to_clear_state", 32'(state_o), 32'd0);
    check("to_clear_err",   32'(err),     32'd0);

    // Done on the final count wins; result 150 saturates.
    reach_run();
    repeat (15) @(negedge clk);
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    check("late_done_state", 32'(state_o), 32'd4);
    check("late_done_err",   32'(err),     32'd0);
    bus.bus_rdata = 32'd150;
    bus.bus_ack   = 1'b1;
    @(negedge clk);
    bus.bus_ack   = 1'b0;
    check("sat_state", 32'(state_o),  32'd5);
    check("sat_disp",  32'(disp_bcd), 32'h99);
    check("sat_err",   32'(err),      32'd1);
    press(K_CLEAR);
    check("sat_clear_err", 32'(err), 32'd0);

    // Reset in the middle of WRITE, with an ack pending.
    press(K_ENTER);
    press(5'd18);
    press(K_ENTER);
    press(K_ENTER);
    fast_write(32'd220, 32'd0);
    bus.bus_ack = 1'b1;
    rst         = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    rst         = 1'b0;
    check("mid_rst_req",   32'(bus.bus_req), 32'd0);
    check("mid_rst_state", 32'(state_o),     32'd0);
    check("mid_rst_addr",  bus.bus_addr,     32'd320);
    check("mid_rst_cpu",   32'(cpu_en),      32'd0);
    press(K_ENTER);
    check("mid_rst_op", 32'(disp_bcd), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
